// File: rtl/spi_cmd_dispatcher_pkg.sv
// Shared definitions for the SPI command dispatcher: command codes, target
// address map, command class / address decode helpers and the FSM states.
package spi_cmd_dispatcher_pkg;

  localparam int PKG_NUM_SLOTS   = 7;
  localparam int PKG_NUM_INTRPTS = 4;
  localparam int PKG_DATA_WIDTH  = 40;

  // Write-class commands
  localparam logic [15:0] C_SET_PWM_FREQ         = 16'h0001;
  localparam logic [15:0] C_SET_PWM_DUTY         = 16'h0002;
  localparam logic [15:0] C_SET_DIG_OUT          = 16'h0003;
  localparam logic [15:0] C_SET_SLOT_TYPE_CONFIG = 16'h0004;
  localparam logic [15:0] C_SET_QUAD_COUNTS      = 16'h0005;
  // Read-class commands
  localparam logic [15:0] C_READ_INTERUPTS       = 16'h0010;
  localparam logic [15:0] C_READ_QUAD_COUNTS     = 16'h0011;
  localparam logic [15:0] C_READ_DIG_IN          = 16'h0012;

  // Target address map; slot n lands on target index n-1, LED is last
  localparam logic [7:0] SLOT_1_ADDRESS = 8'h10;
  localparam logic [7:0] SLOT_2_ADDRESS = 8'h11;
  localparam logic [7:0] SLOT_3_ADDRESS = 8'h12;
  localparam logic [7:0] SLOT_4_ADDRESS = 8'h13;
  localparam logic [7:0] SLOT_5_ADDRESS = 8'h14;
  localparam logic [7:0] SLOT_6_ADDRESS = 8'h15;
  localparam logic [7:0] SLOT_7_ADDRESS = 8'h16;
  localparam logic [7:0] LED_ADDRESS    = 8'h20;
  localparam logic [3:0] LED_INDEX      = 4'd7;

  typedef enum logic [2:0] {
    IDLE,
    GOT_CMD,
    WR_WAIT_DATA,
    RD_WAIT_ACK,
    RD_HOLD
  } state_e;

  typedef enum logic [1:0] {
    CLS_WRITE,
    CLS_RD_INTR,
    CLS_RD_EXT
  } cmd_class_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] idx;
  } addr_dec_t;

  // Anything that is not a write and not the interrupt read goes to a target.
  function automatic cmd_class_e cmd_class(input logic [15:0] cmd);
    cmd_class_e cls;
    case (cmd)
      C_SET_PWM_FREQ, C_SET_PWM_DUTY, C_SET_DIG_OUT,
      C_SET_SLOT_TYPE_CONFIG, C_SET_QUAD_COUNTS: cls = CLS_WRITE;
      C_READ_INTERUPTS:                          cls = CLS_RD_INTR;
      default:                                   cls = CLS_RD_EXT;
    endcase
    return cls;
  endfunction

  function automatic addr_dec_t addr_decode(input logic [7:0] addr);
    addr_dec_t d;
    d.hit = 1'b1;
    case (addr)
      SLOT_1_ADDRESS: d.idx = 4'd0;
      SLOT_2_ADDRESS: d.idx = 4'd1;
      SLOT_3_ADDRESS: d.idx = 4'd2;
      SLOT_4_ADDRESS: d.idx = 4'd3;
      SLOT_5_ADDRESS: d.idx = 4'd4;
      SLOT_6_ADDRESS: d.idx = 4'd5;
      SLOT_7_ADDRESS: d.idx = 4'd6;
      LED_ADDRESS:    d.idx = LED_INDEX;
      default: begin
        d.hit = 1'b0;
        d.idx = 4'd0;
      end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/spi_intr_pending.sv
// Sticky interrupt pending register with clear-on-read. A source that is
// high during the clearing cycle is re-captured so no edge is lost.
module spi_intr_pending #(
  parameter int WIDTH = 28
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] intr_in,
  input  logic             clr,
  output logic [WIDTH-1:0] pending,
  output logic             irq_out
);

  logic [WIDTH-1:0] pending_r;
  logic [WIDTH-1:0] pending_next_s;
  logic             irq_r;

  // Next pending value: clear drops old bits but keeps currently active ones
  always_comb begin
    if (clr) begin
      pending_next_s = intr_in;
    end else begin
      pending_next_s = pending_r | intr_in;
    end
  end

  // Pending bits and the aggregated interrupt, both registered
  always_ff @(posedge clk) begin
    if (reset) begin
      pending_r <= {WIDTH{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      irq_r     <= |pending_next_s;
    end
  end

  assign pending = pending_r;
  assign irq_out = irq_r;

endmodule

// File: rtl/spi_cmd_dispatcher.sv
// Turns the decoded SPI transaction stream into target writes and read-backs.
// Optional build macro DISPATCH_RD_TIMEOUT_EN bounds the wait for rd_ack.
module spi_cmd_dispatcher
  import spi_cmd_dispatcher_pkg::*;
#(
  parameter int NUM_SLOTS      = PKG_NUM_SLOTS,
  parameter int NUM_INTRPTS    = PKG_NUM_INTRPTS,
  parameter int SPI_DATA_WIDTH = PKG_DATA_WIDTH
`ifdef DISPATCH_RD_TIMEOUT_EN
  ,
  parameter int RD_TIMEOUT     = 16
`endif
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [15:0]                      spi_cmd,
  input  logic                             spi_cmd_valid,
  input  logic [7:0]                       spi_addr,
  input  logic                             spi_addr_valid,
  input  logic [SPI_DATA_WIDTH-1:0]        spi_data,
  input  logic                             spi_data_valid,
  input  logic                             spi_done,
  output logic [SPI_DATA_WIDTH-1:0]        spi_sdo,
  output logic                             spi_sdo_valid,
  output logic [NUM_SLOTS:0]               wr_en,
  output logic [15:0]                      wr_cmd,
  output logic [SPI_DATA_WIDTH-1:0]        wr_data,
  output logic                             rd_req,
  output logic [3:0]                       rd_sel,
  output logic [15:0]                      rd_cmd,
  input  logic                             rd_ack,
  input  logic [SPI_DATA_WIDTH-1:0]        rd_data,
  input  logic [NUM_SLOTS*NUM_INTRPTS-1:0] intr_in,
  output logic                             irq_out,
  output logic                             err_pulse
);

  localparam int NUM_PEND = NUM_SLOTS * NUM_INTRPTS;
  localparam logic [NUM_SLOTS:0] WR_ONE = {{NUM_SLOTS{1'b0}}, 1'b1};

  state_e                state_r;
  logic [15:0]           cmd_r;
  logic [3:0]            tgt_r;
  addr_dec_t             dec_s;
  cmd_class_e            cls_s;
  logic                  intr_clr_s;
  logic [NUM_PEND-1:0]   pending_s;

`ifdef DISPATCH_RD_TIMEOUT_EN
  localparam int CNT_W = $clog2(RD_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(RD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  logic [CNT_W-1:0] tmo_cnt_r;
`endif

  // Address/command decode and the interrupt clear strobe for this cycle
  always_comb begin
    dec_s = addr_decode(spi_addr);
    cls_s = cmd_class(cmd_r);
    if (!reset && !spi_done && !spi_cmd_valid && (state_r == GOT_CMD) &&
        spi_addr_valid && dec_s.hit && (cls_s == CLS_RD_INTR)) begin
      intr_clr_s = 1'b1;
    end else begin
      intr_clr_s = 1'b0;
    end
  end

  spi_intr_pending #(
    .WIDTH(NUM_PEND)
  ) u_pending (
    .clk     (clk),
    .reset   (reset),
    .intr_in (intr_in),
    .clr     (intr_clr_s),
    .pending (pending_s),
    .irq_out (irq_out)
  );

  // Transaction sequencer: spi_done, then a misplaced command, take priority
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= IDLE;
      cmd_r         <= 16'h0000;
      tgt_r         <= 4'd0;
      spi_sdo       <= {SPI_DATA_WIDTH{1'b0}};
      spi_sdo_valid <= 1'b0;
      wr_en         <= {(NUM_SLOTS+1){1'b0}};
      wr_cmd        <= 16'h0000;
      wr_data       <= {SPI_DATA_WIDTH{1'b0}};
      rd_req        <= 1'b0;
      rd_sel        <= 4'd0;
      rd_cmd        <= 16'h0000;
      err_pulse     <= 1'b0;
`ifdef DISPATCH_RD_TIMEOUT_EN
      tmo_cnt_r     <= {CNT_W{1'b0}};
`endif
    end else begin
      wr_en         <= {(NUM_SLOTS+1){1'b0}};
      spi_sdo_valid <= 1'b0;
      err_pulse     <= 1'b0;
      if (spi_done) begin
        state_r <= IDLE;
        rd_req  <= 1'b0;
      end else if (spi_cmd_valid && (state_r != IDLE)) begin
        err_pulse <= 1'b1;
        cmd_r     <= spi_cmd;
        rd_req    <= 1'b0;
        state_r   <= GOT_CMD;
      end else begin
        case (state_r)
          IDLE: begin
            if (spi_cmd_valid) begin
              cmd_r   <= spi_cmd;
              state_r <= GOT_CMD;
            end
          end
          GOT_CMD: begin
            if (spi_addr_valid) begin
              if (!dec_s.hit) begin
                err_pulse <= 1'b1;
                state_r   <= RD_HOLD;
              end else begin
                tgt_r <= dec_s.idx;
                case (cls_s)
                  CLS_WRITE: state_r <= WR_WAIT_DATA;
                  CLS_RD_INTR: begin
                    spi_sdo       <= {{(SPI_DATA_WIDTH-NUM_PEND){1'b0}}, pending_s};
                    spi_sdo_valid <= 1'b1;
                    state_r       <= RD_HOLD;
                  end
                  default: begin
                    rd_req  <= 1'b1;
                    rd_sel  <= dec_s.idx;
                    rd_cmd  <= cmd_r;
                    state_r <= RD_WAIT_ACK;
`ifdef DISPATCH_RD_TIMEOUT_EN
                    tmo_cnt_r <= {CNT_W{1'b0}};
`endif
                  end
                endcase
              end
            end
          end
          WR_WAIT_DATA: begin
            if (spi_data_valid) begin
              wr_en   <= WR_ONE << tgt_r;
              wr_cmd  <= cmd_r;
              wr_data <= spi_data;
              state_r <= RD_HOLD;
            end
          end
          RD_WAIT_ACK: begin
            if (rd_ack) begin
              spi_sdo       <= rd_data;
              spi_sdo_valid <= 1'b1;
              rd_req        <= 1'b0;
              state_r       <= RD_HOLD;
            end
`ifdef DISPATCH_RD_TIMEOUT_EN
            else if (tmo_cnt_r == TMO_LAST) begin
              spi_sdo       <= {SPI_DATA_WIDTH{1'b1}};
              spi_sdo_valid <= 1'b1;
              err_pulse     <= 1'b1;
              rd_req        <= 1'b0;
              state_r       <= RD_HOLD;
            end else begin
              tmo_cnt_r <= tmo_cnt_r + CNT_ONE;
            end
`endif
          end
          RD_HOLD: begin
            state_r <= RD_HOLD;
          end
          default: begin
            state_r <= IDLE;
            rd_req  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/spi_cmd_dispatcher.md
# spi_cmd_dispatcher

Sequences the decoded SPI slave transaction stream (command, address, data, done) into per-target register writes and read-backs. Sits in the CPLD core between the SPI slave front end and the slot, LED/PWM and quadrature blocks. Write commands are routed to the addressed target; read commands fetch data and load the slave's MISO shift register before the data phase. Interrupt aggregation with clear-on-read is included.

## Interface
- NUM_SLOTS, 7, number of slot targets; the LED target is one extra
- NUM_INTRPTS, 4, interrupt lines per slot
- SPI_DATA_WIDTH, 40, data-phase width
- RD_TIMEOUT, 16, cycles to wait for rd_ack (timeout build only)
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- spi_cmd / spi_cmd_valid  in  16 / 1  command word and its one-cycle strobe, already in the clk domain
- spi_addr / spi_addr_valid  in  8 / 1  address byte and its strobe
- spi_data / spi_data_valid  in  40 / 1  data word and its strobe
- spi_done  in  1  one-cycle pulse at the end of the transaction (scsn high)
- spi_sdo  out  40  read-back word to the slave shift register
- spi_sdo_valid  out  1  one-cycle load strobe for spi_sdo
- wr_en  out  NUM_SLOTS+1  one-hot write strobe; bit NUM_SLOTS is the LED target
- wr_cmd / wr_data  out  16 / 40  write command and payload, valid while wr_en≠0
- rd_req  out  1  read request level, held until rd_ack
- rd_sel  out  4  target index; 0..NUM_SLOTS-1 are slots, NUM_SLOTS is LED
- rd_cmd  out  16  read command
- rd_ack / rd_data  in  1 / 40  read completion and data
- intr_in  in  NUM_SLOTS*NUM_INTRPTS  level interrupt sources
- irq_out  out  1  OR of the pending interrupt bits
- err_pulse  out  1  one cycle wide on a bad address, a protocol violation or a timeout

## Operation
- FSM states: IDLE, GOT_CMD, WR_WAIT_DATA, RD_WAIT_ACK, RD_HOLD.
- IDLE: on spi_cmd_valid, latch spi_cmd and go to GOT_CMD.
- GOT_CMD: on spi_addr_valid, decode the address using the package SLOT_n_ADDRESS and LED_ADDRESS constants.
  - Unmatched address: pulse err_pulse and go to RD_HOLD. No write and no sdo load occur.
- Write-class command (C_SET_PWM_FREQ, C_SET_PWM_DUTY, C_SET_DIG_OUT, C_SET_SLOT_TYPE_CONFIG, C_SET_QUAD_COUNTS): go to WR_WAIT_DATA.
  - On spi_data_valid, pulse wr_en[target] for one cycle with wr_cmd and wr_data, then go to RD_HOLD.
- C_READ_INTERUPTS: handled internally, no rd_req.
  - spi_sdo = pending bits zero-extended, with spi_sdo_valid pulsed.
  - Pending bits are cleared in the same cycle. An intr_in bit high in that cycle stays pending.
  - Go to RD_HOLD.
- Other read-class commands: assert rd_req with rd_sel and rd_cmd, and go to RD_WAIT_ACK.
  - On rd_ack: spi_sdo = rd_data, pulse spi_sdo_valid, drop rd_req, go to RD_HOLD.
- RD_HOLD: ignores all strobes until spi_done.
- spi_done in any state returns the FSM to IDLE and drops rd_req. A pending write is discarded.
- spi_cmd_valid in any state other than IDLE: pulse err_pulse and restart in GOT_CMD with the new command.
- pending[k] is set when intr_in[k]=1 and cleared only by the interrupt read. irq_out = |pending.

## Timing
- Reset values: all outputs 0, FSM in IDLE, pending = 0.
- Address strobe at cycle N:
  - internal read: spi_sdo_valid at N+1
  - external read: rd_req at N+1
- rd_ack at cycle M: spi_sdo_valid at M+1, and rd_req is low from M+1.
- spi_data_valid at cycle N: wr_en at N+1.
- The SPI front end leaves ≥100 clk cycles between the address and data phases, so the worst-case read latency of RD_TIMEOUT+1 cycles fits.
- Reset mid-transaction aborts immediately. No wr_en or spi_sdo_valid is issued afterwards.

## Configuration
- DISPATCH_RD_TIMEOUT_EN defined: in RD_WAIT_ACK a counter runs from 0.
  - If it reaches RD_TIMEOUT with no rd_ack: spi_sdo = 40'hFF_FFFF_FFFF, spi_sdo_valid and err_pulse pulse, rd_req drops, go to RD_HOLD.
  - A late rd_ack is ignored.
- Not defined: RD_WAIT_ACK waits until rd_ack or spi_done, and no counter is synthesized.

## Structure
- Shared package holds the command codes, the slot/LED address constants, a read/write class-decode function and the FSM state enum.
- One sub-module, spi_intr_pending: the pending register, set/clear logic and irq_out.

## Test plan
- C_SET_PWM_FREQ, LED_ADDRESS, data 40'h01234503e8 -> single wr_en[7] pulse with wr_data 40'h01234503e8; spi_sdo_valid stays 0.
- C_SET_DIG_OUT, SLOT_1_ADDRESS, data 40'h0000000001 -> wr_en = 8'b0000_0001 for one cycle, one cycle after the data strobe.
- intr_in bit 5 high for 3 cycles, then C_READ_INTERUPTS -> spi_sdo = 40'h20, spi_sdo_valid at N+1, irq_out falls. A second read returns 0.
- Quad read with rd_ack after 4 cycles and rd_data 40'h96bd30a647 -> spi_sdo = 40'h96bd30a647. With the timeout build and no ack -> spi_sdo = 40'hFFFFFFFFFF and err_pulse after 16 cycles.
- Address 8'hEE -> err_pulse, no wr_en and no sdo load. The next valid transaction succeeds.
- spi_done between the address and data phases of a write -> no wr_en, FSM back in IDLE. Reset asserted mid-read -> rd_req 0 on the next cycle.
